// File: rtl/hardtanh_arb_pkg.sv
// hardtanh_arb_pkg
//   Shared definitions for the hardtanh stream arbiter: the arbiter state
//   encoding and helpers that produce the most negative / most positive
//   two's complement values for a given element width.
//   No ports (package).
package hardtanh_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Most negative value representable in 'width' signed bits.
  function automatic logic signed [31:0] signedMinOf(input int width);
    return -(32'sd1 <<< (width - 1));
  endfunction

  // Most positive value representable in 'width' signed bits.
  function automatic logic signed [31:0] signedMaxOf(input int width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/hardtanh_skid_buffer.sv
// hardtanh_skid_buffer
//   Two-entry valid/ready register slice. Output is fully registered; the
//   second (skid) entry catches the beat that was in flight when the
//   downstream stalled, so upstream ready is a plain register.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_data/i_valid  upstream payload and valid
//   o_ready         upstream ready (skid entry empty)
//   o_data/o_valid  downstream payload and valid
//   i_ready         downstream ready
module hardtanh_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic             r_skidValid;
  logic [WIDTH-1:0] r_skidData;
  logic             w_inFire;

  assign o_ready  = !r_skidValid;
  assign w_inFire = i_valid && !r_skidValid;
  assign o_valid  = r_outValid;
  assign o_data   = r_outData;

  // When the output register can move, it refills from the skid entry
  // first (preserving order), otherwise straight from the input. When it
  // is stalled, an arriving beat parks in the skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
    end else if (!r_outValid || i_ready) begin
      if (r_skidValid) begin
        r_outData   <= r_skidData;
        r_outValid  <= 1'b1;
        r_skidValid <= 1'b0;
      end else begin
        r_outValid <= w_inFire;
        if (w_inFire) begin
          r_outData <= i_data;
        end
      end
    end else if (w_inFire) begin
      r_skidData  <= i_data;
      r_skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/hardtanh_stream_arbiter.sv
// hardtanh_stream_arbiter
//   Shares one PARALLELISM-lane hardtanh clamp between NUM_REQ requester
//   streams. Round-robin grant, held for a whole tensor of TENSOR_BEATS
//   beats. Each requester owns a min/max bound pair in config registers;
//   the pair is copied into the active bounds at grant time.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   data_in/_valid/_ready    packed requester beats (requester r at slice r)
//   data_out/_id/_last       clamped beat, producing requester, tensor end
//   data_out_valid/_ready    output handshake
//   cfg_wr_en/_id/_min/_max  bound write port; cfg_err pulses on min>max
//   sat_count/_valid         clamped-element count per tensor
// Optional feature macro: HARDTANH_SAT_STATS_EN (saturation statistics).
module hardtanh_stream_arbiter
  import hardtanh_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int PARALLELISM  = 4,
  parameter int TENSOR_BEATS = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0]  data_in,
  input  logic [NUM_REQ-1:0]                         data_in_valid,
  output logic [NUM_REQ-1:0]                         data_in_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0]          data_out,
  output logic [ID_WIDTH-1:0]                        data_out_id,
  output logic                                       data_out_last,
  output logic                                       data_out_valid,
  input  logic                                       data_out_ready,
  input  logic                                       cfg_wr_en,
  input  logic [ID_WIDTH-1:0]                        cfg_wr_id,
  input  logic [DATA_WIDTH-1:0]                      cfg_wr_min,
  input  logic [DATA_WIDTH-1:0]                      cfg_wr_max,
  output logic                                       cfg_err,
  output logic [$clog2(TENSOR_BEATS*PARALLELISM+1)-1:0] sat_count,
  output logic                                       sat_count_valid
);

  localparam int PW  = PARALLELISM * DATA_WIDTH;
  localparam int SKW = PW + ID_WIDTH + 1;
  localparam int CW  = $clog2(TENSOR_BEATS * PARALLELISM + 1);
  localparam int BW  = (TENSOR_BEATS > 1) ? $clog2(TENSOR_BEATS) : 1;
  localparam logic [DATA_WIDTH-1:0] BOUND_MIN = DATA_WIDTH'(signedMinOf(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] BOUND_MAX = DATA_WIDTH'(signedMaxOf(DATA_WIDTH));

  arb_state_t              r_state;
  logic [ID_WIDTH-1:0]     r_grant;
  logic [ID_WIDTH-1:0]     r_rrPtr;
  logic [BW-1:0]           r_beatCnt;
  logic [DATA_WIDTH-1:0]   r_actMin;
  logic [DATA_WIDTH-1:0]   r_actMax;
  logic [DATA_WIDTH-1:0]   r_cfgMin [NUM_REQ];
  logic [DATA_WIDTH-1:0]   r_cfgMax [NUM_REQ];
  logic                    r_cfgErr;

  logic [PW-1:0]           w_reqBeat [NUM_REQ];
  logic [PW-1:0]           w_selBeat;
  logic [PW-1:0]           w_clampBeat;
  logic [ID_WIDTH-1:0]     w_pick;
  logic [ID_WIDTH-1:0]     w_idx;
  logic                    w_found;
  logic                    w_skidReady;
  logic                    w_accept;
  logic                    w_lastBeat;
  logic [SKW-1:0]          w_skidOut;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_reqBeat[g] = data_in[g*PW +: PW];
  end

  assign w_selBeat  = w_reqBeat[r_grant];
  assign w_accept   = (r_state == LOCKED) && data_in_valid[r_grant] && w_skidReady;
  assign w_lastBeat = (r_beatCnt == BW'(TENSOR_BEATS - 1));
  assign cfg_err    = r_cfgErr;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rrPtr;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_WIDTH'((int'(r_rrPtr) + i) % NUM_REQ);
      if (!w_found && data_in_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Only the lock holder sees ready, and only while the buffer has room.
  always_comb begin
    data_in_ready = '0;
    if (r_state == LOCKED) begin
      data_in_ready[r_grant] = w_skidReady;
    end
  end

  // Per-lane signed clamp against the bounds latched at grant.
  always_comb begin
    w_clampBeat = w_selBeat;
    for (int l = 0; l < PARALLELISM; l++) begin
      if ($signed(w_selBeat[l*DATA_WIDTH +: DATA_WIDTH]) < $signed(r_actMin)) begin
        w_clampBeat[l*DATA_WIDTH +: DATA_WIDTH] = r_actMin;
      end else if ($signed(w_selBeat[l*DATA_WIDTH +: DATA_WIDTH]) > $signed(r_actMax)) begin
        w_clampBeat[l*DATA_WIDTH +: DATA_WIDTH] = r_actMax;
      end
    end
  end

  // Arbiter FSM: grant in IDLE (latching the bound pair), then hold the
  // lock until the final beat of the tensor is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
      r_actMin  <= BOUND_MIN;
      r_actMax  <= BOUND_MAX;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant   <= w_pick;
            r_actMin  <= r_cfgMin[w_pick];
            r_actMax  <= r_cfgMax[w_pick];
            r_beatCnt <= '0;
            r_state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept) begin
            if (w_lastBeat) begin
              r_beatCnt <= '0;
              r_state   <= IDLE;
              r_rrPtr   <= (r_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant + ID_WIDTH'(1);
            end else begin
              r_beatCnt <= r_beatCnt + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bound registers. Inverted pairs are dropped and flagged; a grant in
  // the same cycle as a write reads the pre-write value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfgErr <= 1'b0;
      for (int r = 0; r < NUM_REQ; r++) begin
        r_cfgMin[r] <= BOUND_MIN;
        r_cfgMax[r] <= BOUND_MAX;
      end
    end else begin
      r_cfgErr <= 1'b0;
      if (cfg_wr_en) begin
        if ($signed(cfg_wr_min) > $signed(cfg_wr_max)) begin
          r_cfgErr <= 1'b1;
        end else begin
          r_cfgMin[cfg_wr_id] <= cfg_wr_min;
          r_cfgMax[cfg_wr_id] <= cfg_wr_max;
        end
      end
    end
  end

  hardtanh_skid_buffer #(
    .WIDTH(SKW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({w_clampBeat, r_grant, w_lastBeat}),
    .i_valid (w_accept),
    .o_ready (w_skidReady),
    .o_data  (w_skidOut),
    .o_valid (data_out_valid),
    .i_ready (data_out_ready)
  );

  assign data_out      = w_skidOut[SKW-1 -: PW];
  assign data_out_id   = w_skidOut[ID_WIDTH:1];
  assign data_out_last = w_skidOut[0];

`ifdef HARDTANH_SAT_STATS_EN
  logic [CW-1:0] w_beatSat;
  logic [CW-1:0] r_satRun;
  logic [CW-1:0] r_satPending;

  // A lane was clamped exactly when its output differs from its input.
  always_comb begin
    w_beatSat = '0;
    for (int l = 0; l < PARALLELISM; l++) begin
      if (w_selBeat[l*DATA_WIDTH +: DATA_WIDTH] != w_clampBeat[l*DATA_WIDTH +: DATA_WIDTH]) begin
        w_beatSat = w_beatSat + CW'(1);
      end
    end
  end

  // The finished tensor's total is parked until its last beat leaves the
  // buffer, so a following tensor can start counting meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_satRun     <= '0;
      r_satPending <= '0;
    end else if (w_accept) begin
      if (w_lastBeat) begin
        r_satPending <= r_satRun + w_beatSat;
        r_satRun     <= '0;
      end else begin
        r_satRun <= r_satRun + w_beatSat;
      end
    end
  end

  assign sat_count_valid = data_out_valid && data_out_ready && data_out_last;
  assign sat_count       = sat_count_valid ? r_satPending : '0;
`else
  assign sat_count_valid = 1'b0;
  assign sat_count       = '0;
`endif

endmodule

// File: tb/tb_hardtanh_stream_arbiter.sv
// tb_hardtanh_stream_arbiter
//   Directed bench for hardtanh_stream_arbiter with default parameters
//   (2 requesters, 8-bit elements, 4 lanes, 4-beat tensors). Lane 0 is the
//   least significant byte of each 32-bit beat.
module tb_hardtanh_stream_arbiter;

  localparam int NR     = 2;
  localparam int DW     = 8;
  localparam int PAR    = 4;
  localparam int TBEATS = 4;
  localparam int IDW    = 1;
  localparam int SCW    = 5;
  localparam int BEATW  = PAR * DW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NR*BEATW-1:0]     data_in;
  logic [NR-1:0]           data_in_valid;
  logic [NR-1:0]           data_in_ready;
  logic [BEATW-1:0]        data_out;
  logic [IDW-1:0]          data_out_id;
  logic                    data_out_last;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic                    cfg_wr_en;
  logic [IDW-1:0]          cfg_wr_id;
  logic [DW-1:0]           cfg_wr_min;
  logic [DW-1:0]           cfg_wr_max;
  logic                    cfg_err;
  logic [SCW-1:0]          sat_count;
  logic                    sat_count_valid;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    int          req;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [31:0] beat;
    logic [31:0] expBeat;
    int          expSat;
  } vec_t;

  vec_t vecs [5];

  hardtanh_stream_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .PARALLELISM  (PAR),
    .TENSOR_BEATS (TBEATS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .data_out        (data_out),
    .data_out_id     (data_out_id),
    .data_out_last   (data_out_last),
    .data_out_valid  (data_out_valid),
    .data_out_ready  (data_out_ready),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_id       (cfg_wr_id),
    .cfg_wr_min      (cfg_wr_min),
    .cfg_wr_max      (cfg_wr_max),
    .cfg_err         (cfg_err),
    .sat_count       (sat_count),
    .sat_count_valid (sat_count_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input int id, input logic [7:0] mn, input logic [7:0] mx);
    cfg_wr_en  = 1'b1;
    cfg_wr_id  = IDW'(id);
    cfg_wr_min = mn;
    cfg_wr_max = mx;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 128'(data_out_valid), 128'(0));
    checkOutput({tag, "_last"}, 128'(data_out_last), 128'(0));
    checkOutput({tag, "_id"}, 128'(data_out_id), 128'(0));
    checkOutput({tag, "_data"}, 128'(data_out), 128'(0));
    checkOutput({tag, "_ready"}, 128'(data_in_ready), 128'(0));
    checkOutput({tag, "_cfgErr"}, 128'(cfg_err), 128'(0));
    checkOutput({tag, "_satCount"}, 128'(sat_count), 128'(0));
    checkOutput({tag, "_satValid"}, 128'(sat_count_valid), 128'(0));
  endtask

  // Streams one tensor from a single requester with downstream always
  // ready. Optionally issues one config write when 'midWriteAt' beats have
  // been accepted (0 means on the grant edge).
  task automatic applyStimulus(input int req, input logic [127:0] beats, input logic [127:0] exps,
                               input int expSat, input int midWriteAt,
                               input logic [7:0] wrMin, input logic [7:0] wrMax,
                               output int firstCyc);
    int  accepted;
    int  outs;
    int  cyc;
    bit  willAccept;
    bit  wrote;
    accepted = 0;
    outs     = 0;
    cyc      = 0;
    wrote    = 1'b0;
    firstCyc = -1;
    data_out_ready = 1'b1;
    data_in[req*BEATW +: BEATW] = beats[0 +: BEATW];
    data_in_valid      = '0;
    data_in_valid[req] = 1'b1;
    while (outs < TBEATS && cyc < 60) begin
      willAccept = data_in_valid[req] && data_in_ready[req];
      if (!wrote && midWriteAt >= 0 && accepted == midWriteAt) begin
        cfg_wr_en  = 1'b1;
        cfg_wr_id  = IDW'(req);
        cfg_wr_min = wrMin;
        cfg_wr_max = wrMax;
        wrote      = 1'b1;
      end else begin
        cfg_wr_en = 1'b0;
      end
      step();
      cyc++;
      if (willAccept) begin
        accepted++;
        if (accepted == TBEATS) begin
          data_in_valid = '0;
        end else begin
          data_in[req*BEATW +: BEATW] = beats[accepted*BEATW +: BEATW];
        end
      end
      if (data_out_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        checkOutput("tensorData", 128'(data_out), 128'(exps[outs*BEATW +: BEATW]));
        checkOutput("tensorId", 128'(data_out_id), 128'(req));
        checkOutput("tensorLast", 128'(data_out_last), 128'(outs == TBEATS - 1));
`ifdef HARDTANH_SAT_STATS_EN
        checkOutput("satValid", 128'(sat_count_valid), 128'(outs == TBEATS - 1));
        if (outs == TBEATS - 1) checkOutput("satCount", 128'(sat_count), 128'(expSat));
`else
        checkOutput("satValidOff", 128'(sat_count_valid), 128'(0));
`endif
        outs++;
      end
    end
    cfg_wr_en = 1'b0;
    if (outs < TBEATS) checkOutput("tensorTimeout", 128'(outs), 128'(TBEATS));
  endtask

  function automatic logic [31:0] bpBeat(input int k);
    logic [7:0] b;
    b = 8'(k * 4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    int          lat;
    int          accepted;
    int          outs;
    int          cyc;
    int          expId;
    bit          willAccept;
    bit          prevStall;
    logic [40:0] prevWord;
    logic [15:0] readyPat;

    vecs[0] = '{0, 8'hF6, 8'h14, 32'h7F05F680, 32'h1405F6F6, 8};
    vecs[1] = '{1, 8'h00, 8'h00, 32'h01FF8000, 32'h00000000, 12};
    vecs[2] = '{1, 8'h80, 8'h7F, 32'h807F01FF, 32'h807F01FF, 0};
    vecs[3] = '{0, 8'hCE, 8'hEC, 32'hEDECCECD, 32'hECECCECE, 8};
    vecs[4] = '{1, 8'h1E, 8'h64, 32'h64651D1E, 32'h64641E1E, 8};

    rst            = 1'b0;
    data_in        = '0;
    data_in_valid  = '0;
    data_out_ready = 1'b1;
    cfg_wr_en      = 1'b0;
    cfg_wr_id      = '0;
    cfg_wr_min     = '0;
    cfg_wr_max     = '0;
    repeat (3) step();
    checkResetOutputs("reset");
    rst = 1'b1;
    step();

    // Table-driven clamp vectors, each a single-requester tensor.
    for (int i = 0; i < 5; i++) begin
      cfgWrite(vecs[i].req, vecs[i].mn, vecs[i].mx);
      checkOutput("cfgErrQuiet", 128'(cfg_err), 128'(0));
      applyStimulus(vecs[i].req, {4{vecs[i].beat}}, {4{vecs[i].expBeat}}, vecs[i].expSat, -1, 8'h0, 8'h0, lat);
      checkOutput("latency", 128'(lat), 128'(2));
    end

    // Inverted bounds are rejected; req0 keeps (-50,-20).
    cfgWrite(0, 8'h05, 8'hFB);
    checkOutput("cfgErrPulse", 128'(cfg_err), 128'(1));
    step();
    checkOutput("cfgErrOnce", 128'(cfg_err), 128'(0));
    applyStimulus(0, {4{32'h7F05F680}}, {4{32'hECECECCE}}, 16, -1, 8'h0, 8'h0, lat);

    // Write to the lock holder mid-tensor: current tensor keeps old bounds.
    cfgWrite(0, 8'hF6, 8'h14);
    applyStimulus(0, {4{32'h7F05F680}}, {4{32'h1405F6F6}}, 8, 1, 8'h00, 8'h00, lat);
    applyStimulus(0, {4{32'h7F05F680}}, {4{32'h00000000}}, 16, -1, 8'h0, 8'h0, lat);

    // Write on the grant edge: grant still latches the old (0,0) bounds.
    applyStimulus(0, {4{32'h7F05F680}}, {4{32'h00000000}}, 16, 0, 8'hF6, 8'h14, lat);
    applyStimulus(0, {4{32'h7F05F680}}, {4{32'h1405F6F6}}, 8, -1, 8'h0, 8'h0, lat);

    // Five clamped elements out of sixteen, bounds (-10,20).
    applyStimulus(0, {32'h0000F514, 32'h15000000, 32'h00000015, 32'h7F05F680},
                  {32'h0000F614, 32'h14000000, 32'h00000014, 32'h1405F6F6}, 5, -1, 8'h0, 8'h0, lat);

    // Asynchronous reset after two beats of a tensor.
    data_in[0 +: BEATW] = 32'h11111111;
    data_in_valid = 2'b01;
    accepted = 0;
    cyc = 0;
    while (accepted < 2 && cyc < 20) begin
      willAccept = data_in_valid[0] && data_in_ready[0];
      step();
      cyc++;
      if (willAccept) accepted++;
    end
    checkOutput("preResetValid", 128'(data_out_valid), 128'(1));
    rst = 1'b0;
    #1;
    checkResetOutputs("midReset");
    data_in_valid = '0;
    step();
    rst = 1'b1;
    step();
    applyStimulus(1, {4{32'h807F01FF}}, {4{32'h807F01FF}}, 0, -1, 8'h0, 8'h0, lat);
    checkOutput("postResetLatency", 128'(lat), 128'(2));

    // Both requesters valid: tensors 0,1,0,1 with one bubble between them.
    data_in = {32'h55667788, 32'h11223344};
    data_in_valid  = 2'b11;
    data_out_ready = 1'b1;
    outs = 0;
    cyc  = 0;
    lat  = 0;
    while (outs < 16 && cyc < 60) begin
      step();
      cyc++;
      if (data_out_valid) begin
        expId = (outs / 4) % 2;
        checkOutput("rrId", 128'(data_out_id), 128'(expId));
        checkOutput("rrData", 128'(data_out), 128'((expId == 0) ? 32'h11223344 : 32'h55667788));
        checkOutput("rrLast", 128'(data_out_last), 128'((outs % 4) == 3));
        outs++;
        lat = cyc;
      end
    end
    data_in_valid = '0;
    checkOutput("rrCount", 128'(outs), 128'(16));
    checkOutput("rrLastCycle", 128'(lat), 128'(20));
    step();
    step();

    // Backpressure: requester 1 sends two tensors of distinct beats while
    // downstream ready follows a fixed stall pattern.
    readyPat = 16'b1100_1010_0111_0001;
    data_in[BEATW +: BEATW] = bpBeat(0);
    data_in_valid = 2'b10;
    accepted  = 0;
    outs      = 0;
    cyc       = 0;
    prevStall = 1'b0;
    prevWord  = '0;
    while (outs < 8 && cyc < 200) begin
      data_out_ready = readyPat[cyc % 16];
      if (prevStall) begin
        checkOutput("stallStable", 128'({data_out_valid, data_out_last, data_out_id, data_out}), 128'(prevWord));
      end
      if (data_out_valid && data_out_ready) begin
        checkOutput("bpData", 128'(data_out), 128'(bpBeat(outs)));
        checkOutput("bpId", 128'(data_out_id), 128'(1));
        checkOutput("bpLast", 128'(data_out_last), 128'((outs % 4) == 3));
        outs++;
      end
      prevStall  = data_out_valid && !data_out_ready;
      prevWord   = {data_out_valid, data_out_last, data_out_id, data_out};
      willAccept = data_in_valid[1] && data_in_ready[1];
      step();
      cyc++;
      if (willAccept) begin
        accepted++;
        if (accepted == 8) data_in_valid = '0;
        else data_in[BEATW +: BEATW] = bpBeat(accepted);
      end
    end
    checkOutput("bpCount", 128'(outs), 128'(8));
    data_out_ready = 1'b1;
    step();
    step();
    checkOutput("drained", 128'(data_out_valid), 128'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
